// File: rtl/sa_col_weight_feeder_if.sv
// Handshake and column-edge bundle for sa_col_weight_feeder.
// The master side supplies weights and commands; the slave side (the feeder)
// answers with ready/status and drives the top edge of one PE column.
// Optional macro FD_BIAS_EN adds the bias capture signals.
interface sa_col_weight_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  FD_w_valid;
  logic                  FD_w_ready;
  logic [DATA_WIDTH-1:0] FD_w_data;
  logic                  FD_load_start;
  logic                  FD_en_up;
  logic [DATA_WIDTH-1:0] FD_data_up;
  logic                  FD_load_busy;
  logic                  FD_load_done;
  logic                  FD_col_loaded;
`ifdef FD_BIAS_EN
  logic                  FD_bias_valid;
  logic [DATA_WIDTH-1:0] FD_bias_data;

  modport master (
    output FD_w_valid, FD_w_data, FD_load_start, FD_bias_valid, FD_bias_data,
    input  FD_w_ready, FD_en_up, FD_data_up, FD_load_busy, FD_load_done, FD_col_loaded
  );

  modport slave (
    input  FD_w_valid, FD_w_data, FD_load_start, FD_bias_valid, FD_bias_data,
    output FD_w_ready, FD_en_up, FD_data_up, FD_load_busy, FD_load_done, FD_col_loaded
  );
`else
  modport master (
    output FD_w_valid, FD_w_data, FD_load_start,
    input  FD_w_ready, FD_en_up, FD_data_up, FD_load_busy, FD_load_done, FD_col_loaded
  );

  modport slave (
    input  FD_w_valid, FD_w_data, FD_load_start,
    output FD_w_ready, FD_en_up, FD_data_up, FD_load_busy, FD_load_done, FD_col_loaded
  );
`endif
endinterface

// File: rtl/sa_col_weight_feeder.sv
// Top-of-column weight feeder for the systolic array.
// Collects ROWS weights over valid/ready, then on FD_load_start pushes them
// deepest-row-first into the PE column's weight chain, waits for the store
// enable to ripple to the last row, and reports completion.
// Outside of a load, FD_data_up carries the partial-sum seed: zero by default,
// or a captured bias register when the macro FD_BIAS_EN is defined.
module sa_col_weight_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4
) (
  input logic              FD_clk,
  input logic              FD_rst,
  sa_col_weight_feeder_if.slave fd
);

  // Count must hold the value ROWS; the buffer index only needs ROWS entries.
  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] ROWS_C     = CNT_W'(ROWS);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = (ROWS > 1) ? CNT_W'(ROWS - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    SHIFT,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      k_q, k_d;
  logic                  en_up_q, en_up_d;
  logic [DATA_WIDTH-1:0] data_up_q, data_up_d;
  logic                  done_q, done_d;
  logic                  col_loaded_q, col_loaded_d;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] seed;
  logic                  wr_fire;

  // Power-of-two sized so any IDX_W-bit index is in range; contents need no reset.
  logic [DATA_WIDTH-1:0] wbuf_q [2**IDX_W];

  assign fd.FD_w_ready    = !FD_rst && (state_q == IDLE) && (count_q < ROWS_C);
  assign fd.FD_load_busy  = (state_q == SHIFT) || (state_q == DRAIN);
  assign fd.FD_en_up      = en_up_q;
  assign fd.FD_data_up    = data_up_q;
  assign fd.FD_load_done  = done_q;
  assign fd.FD_col_loaded = col_loaded_q;

  assign wr_fire = fd.FD_w_valid && fd.FD_w_ready;

`ifdef FD_BIAS_EN
  logic [DATA_WIDTH-1:0] bias_q, bias_d;

  // A bias write is visible to the seed on the same edge it is captured, so a
  // write during the final shift cycle already seeds the first drain cycle.
  always_comb begin
    bias_d = fd.FD_bias_valid ? fd.FD_bias_data : bias_q;
  end

  // Bias register, writable in any state.
  always_ff @(posedge FD_clk) begin
    if (FD_rst) begin
      bias_q <= '0;
    end else begin
      bias_q <= bias_d;
    end
  end

  assign seed = bias_d;
`else
  assign seed = '0;
`endif

  // Capture accepted weight words in arrival order.
  always_ff @(posedge FD_clk) begin
    if (wr_fire) begin
      wbuf_q[IDX_W'(count_q)] <= fd.FD_w_data;
    end
  end

  // Next-state logic; registered outputs are computed here so they line up
  // with the state they belong to rather than trailing it by a cycle.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    k_d          = k_q;
    en_up_d      = 1'b0;
    data_up_d    = seed;
    done_d       = 1'b0;
    col_loaded_d = col_loaded_q;
    rd_idx       = '0;

    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = FULL;
          end
        end
      end

      FULL: begin
        if (fd.FD_load_start) begin
          state_d      = SHIFT;
          k_d          = '0;
          col_loaded_d = 1'b0;
          en_up_d      = 1'b1;
          rd_idx       = IDX_W'(LAST_CNT);
          data_up_d    = wbuf_q[rd_idx];
        end
      end

      SHIFT: begin
        if (k_q == LAST_CNT) begin
          if (ROWS == 1) begin
            state_d      = IDLE;
            k_d          = '0;
            count_d      = '0;
            done_d       = 1'b1;
            col_loaded_d = 1'b1;
          end else begin
            state_d = DRAIN;
            k_d     = '0;
          end
        end else begin
          k_d       = k_q + CNT_W'(1);
          en_up_d   = 1'b1;
          rd_idx    = IDX_W'(LAST_CNT - k_d);
          data_up_d = wbuf_q[rd_idx];
        end
      end

      DRAIN: begin
        if (k_q == DRAIN_LAST) begin
          state_d      = IDLE;
          k_d          = '0;
          count_d      = '0;
          done_d       = 1'b1;
          col_loaded_d = 1'b1;
        end else begin
          k_d = k_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any load in progress.
  always_ff @(posedge FD_clk) begin
    if (FD_rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      k_q          <= '0;
      en_up_q      <= 1'b0;
      data_up_q    <= '0;
      done_q       <= 1'b0;
      col_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      k_q          <= k_d;
      en_up_q      <= en_up_d;
      data_up_q    <= data_up_d;
      done_q       <= done_d;
      col_loaded_q <= col_loaded_d;
    end
  end

endmodule

// File: tb/tb_sa_col_weight_feeder.sv
// Directed bench for sa_col_weight_feeder: a 4-row instance with a small
// shift-chain model of the PE column, plus a 1-row instance.
// Bias checks are compiled in when FD_BIAS_EN is defined.
module tb_sa_col_weight_feeder;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  int numChecks = 0;
  int numFails  = 0;

  always #5 clk = ~clk;

  sa_col_weight_feeder_if #(.DATA_WIDTH(DW)) if4 ();
  sa_col_weight_feeder_if #(.DATA_WIDTH(DW)) if1 ();

  sa_col_weight_feeder #(.DATA_WIDTH(DW), .ROWS(4)) dut4 (
    .FD_clk (clk),
    .FD_rst (rst),
    .fd     (if4)
  );

  sa_col_weight_feeder #(.DATA_WIDTH(DW), .ROWS(1)) dut1 (
    .FD_clk (clk),
    .FD_rst (rst),
    .fd     (if1)
  );

  // Column model: each store-enabled push shifts the chain down one row.
  logic [DW-1:0] peRow [4];
  always @(posedge clk) begin
    if (if4.FD_en_up) begin
      peRow[0] <= if4.FD_data_up;
      for (int r = 1; r < 4; r++) peRow[r] <= peRow[r-1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    numChecks++; if (if4.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL reset_en_up: got %b expected 0", if4.FD_en_up); end
    numChecks++; if (if4.FD_data_up !== '0) begin numFails++; $display("[TB] FAIL reset_data_up: got %0d expected 0", if4.FD_data_up); end
    numChecks++; if (if4.FD_load_busy !== 1'b0) begin numFails++; $display("[TB] FAIL reset_busy: got %b expected 0", if4.FD_load_busy); end
    numChecks++; if (if4.FD_load_done !== 1'b0) begin numFails++; $display("[TB] FAIL reset_done: got %b expected 0", if4.FD_load_done); end
    numChecks++; if (if4.FD_col_loaded !== 1'b0) begin numFails++; $display("[TB] FAIL reset_col_loaded: got %b expected 0", if4.FD_col_loaded); end
    numChecks++; if (if4.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL reset_ready_in_reset: got %b expected 0", if4.FD_w_ready); end
    rst = 1'b0;
    #1;
    numChecks++; if (if4.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL reset_ready_released: got %b expected 1", if4.FD_w_ready); end
    numChecks++; if (if1.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL reset_ready_rows1: got %b expected 1", if1.FD_w_ready); end
  endtask

  task automatic test_basic_load();
    logic expEn, expDone, expCol, expBusy;
    logic [DW-1:0] expData;
    tick();
    for (int i = 0; i < 4; i++) begin
      if4.FD_w_valid = 1'b1;
      if4.FD_w_data  = DW'((i + 1) * 10);
      numChecks++; if (if4.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL basic_ready_word%0d: got %b expected 1", i, if4.FD_w_ready); end
      tick();
    end
    if4.FD_w_valid = 1'b0;
    numChecks++; if (if4.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL basic_ready_full: got %b expected 0", if4.FD_w_ready); end
    if4.FD_load_start = 1'b1;
    tick();
    if4.FD_load_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      expEn   = (c <= 4);
      expData = expEn ? DW'(50 - 10 * c) : '0;
      expDone = (c == 8);
      expCol  = (c >= 8);
      expBusy = (c <= 7);
      numChecks++; if (if4.FD_en_up !== expEn) begin numFails++; $display("[TB] FAIL basic_en_up c%0d: got %b expected %b", c, if4.FD_en_up, expEn); end
      numChecks++; if (if4.FD_data_up !== expData) begin numFails++; $display("[TB] FAIL basic_data_up c%0d: got %0d expected %0d", c, if4.FD_data_up, expData); end
      numChecks++; if (if4.FD_load_done !== expDone) begin numFails++; $display("[TB] FAIL basic_done c%0d: got %b expected %b", c, if4.FD_load_done, expDone); end
      numChecks++; if (if4.FD_col_loaded !== expCol) begin numFails++; $display("[TB] FAIL basic_col_loaded c%0d: got %b expected %b", c, if4.FD_col_loaded, expCol); end
      numChecks++; if (if4.FD_load_busy !== expBusy) begin numFails++; $display("[TB] FAIL basic_busy c%0d: got %b expected %b", c, if4.FD_load_busy, expBusy); end
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      numChecks++; if (peRow[r] !== DW'((r + 1) * 10)) begin numFails++; $display("[TB] FAIL basic_pe_row%0d: got %0d expected %0d", r, peRow[r], (r + 1) * 10); end
    end
  endtask

  task automatic test_early_start();
    for (int i = 0; i < 3; i++) begin
      if4.FD_w_valid = 1'b1;
      if4.FD_w_data  = DW'(i + 1);
      tick();
    end
    if4.FD_w_valid    = 1'b0;
    if4.FD_load_start = 1'b1;
    tick();
    if4.FD_load_start = 1'b0;
    numChecks++; if (if4.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL early3_en_up: got %b expected 0", if4.FD_en_up); end
    numChecks++; if (if4.FD_load_busy !== 1'b0) begin numFails++; $display("[TB] FAIL early3_busy: got %b expected 0", if4.FD_load_busy); end
    numChecks++; if (if4.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL early3_ready: got %b expected 1", if4.FD_w_ready); end
    if4.FD_w_valid    = 1'b1;
    if4.FD_w_data     = DW'(4);
    if4.FD_load_start = 1'b1;
    tick();
    if4.FD_w_valid    = 1'b0;
    if4.FD_load_start = 1'b0;
    numChecks++; if (if4.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL early4_en_up: got %b expected 0", if4.FD_en_up); end
    numChecks++; if (if4.FD_load_busy !== 1'b0) begin numFails++; $display("[TB] FAIL early4_busy: got %b expected 0", if4.FD_load_busy); end
    numChecks++; if (if4.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL early4_ready: got %b expected 0", if4.FD_w_ready); end
    numChecks++; if (if4.FD_col_loaded !== 1'b1) begin numFails++; $display("[TB] FAIL early4_col_loaded: got %b expected 1", if4.FD_col_loaded); end
    tick();
    numChecks++; if (if4.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL early_full_en_up: got %b expected 0", if4.FD_en_up); end
    if4.FD_load_start = 1'b1;
    tick();
    if4.FD_load_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      numChecks++; if (if4.FD_en_up !== (c <= 4)) begin numFails++; $display("[TB] FAIL early_en_up c%0d: got %b expected %b", c, if4.FD_en_up, (c <= 4)); end
      numChecks++; if (if4.FD_data_up !== ((c <= 4) ? DW'(5 - c) : '0)) begin numFails++; $display("[TB] FAIL early_data_up c%0d: got %0d expected %0d", c, if4.FD_data_up, (c <= 4) ? 5 - c : 0); end
      numChecks++; if (if4.FD_load_done !== (c == 8)) begin numFails++; $display("[TB] FAIL early_done c%0d: got %b expected %b", c, if4.FD_load_done, (c == 8)); end
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      numChecks++; if (peRow[r] !== DW'(r + 1)) begin numFails++; $display("[TB] FAIL early_pe_row%0d: got %0d expected %0d", r, peRow[r], r + 1); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if4.FD_w_valid = 1'b1;
      if4.FD_w_data  = DW'(5 + i);
      tick();
    end
    if4.FD_w_data     = 32'h0000DEAD;
    if4.FD_load_start = 1'b1;
    tick();
    for (int c = 1; c <= 12; c++) begin
      if4.FD_load_start = (c == 2) || (c == 5);
      numChecks++; if (if4.FD_en_up !== (c <= 4)) begin numFails++; $display("[TB] FAIL b2b_en_up c%0d: got %b expected %b", c, if4.FD_en_up, (c <= 4)); end
      numChecks++; if (if4.FD_data_up !== ((c <= 4) ? DW'(9 - c) : '0)) begin numFails++; $display("[TB] FAIL b2b_data_up c%0d: got %0d expected %0d", c, if4.FD_data_up, (c <= 4) ? 9 - c : 0); end
      numChecks++; if (if4.FD_load_done !== (c == 8)) begin numFails++; $display("[TB] FAIL b2b_done c%0d: got %b expected %b", c, if4.FD_load_done, (c == 8)); end
      numChecks++; if (if4.FD_w_ready !== (c >= 8)) begin numFails++; $display("[TB] FAIL b2b_ready c%0d: got %b expected %b", c, if4.FD_w_ready, (c >= 8)); end
      if (c == 8) if4.FD_w_valid = 1'b0;
      tick();
    end
    if4.FD_load_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      numChecks++; if (peRow[r] !== DW'(5 + r)) begin numFails++; $display("[TB] FAIL b2b_pe_row%0d: got %0d expected %0d", r, peRow[r], 5 + r); end
    end
    for (int i = 0; i < 4; i++) begin
      if4.FD_w_valid = 1'b1;
      if4.FD_w_data  = DW'(100 + i);
      numChecks++; if (if4.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL b2b_refill_ready%0d: got %b expected 1", i, if4.FD_w_ready); end
      tick();
    end
    if4.FD_w_valid = 1'b0;
    numChecks++; if (if4.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL b2b_refill_full: got %b expected 0", if4.FD_w_ready); end
  endtask

  task automatic test_reset_mid_shift();
    if4.FD_load_start = 1'b1;
    tick();
    if4.FD_load_start = 1'b0;
    tick();
    numChecks++; if (if4.FD_data_up !== DW'(102)) begin numFails++; $display("[TB] FAIL rstmid_data_c2: got %0d expected 102", if4.FD_data_up); end
    rst = 1'b1;
    tick();
    numChecks++; if (if4.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_en_up: got %b expected 0", if4.FD_en_up); end
    numChecks++; if (if4.FD_data_up !== '0) begin numFails++; $display("[TB] FAIL rstmid_data_up: got %0d expected 0", if4.FD_data_up); end
    numChecks++; if (if4.FD_col_loaded !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_col_loaded: got %b expected 0", if4.FD_col_loaded); end
    numChecks++; if (if4.FD_load_busy !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_busy: got %b expected 0", if4.FD_load_busy); end
    numChecks++; if (if4.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_ready_in_reset: got %b expected 0", if4.FD_w_ready); end
    rst = 1'b0;
    #1;
    numChecks++; if (if4.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL rstmid_ready_released: got %b expected 1", if4.FD_w_ready); end
    for (int c = 0; c < 8; c++) begin
      tick();
      numChecks++; if (if4.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_post_en_up%0d: got %b expected 0", c, if4.FD_en_up); end
      numChecks++; if (if4.FD_load_done !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_post_done%0d: got %b expected 0", c, if4.FD_load_done); end
    end
    for (int i = 0; i < 4; i++) begin
      if4.FD_w_valid = 1'b1;
      if4.FD_w_data  = DW'(21 + i);
      numChecks++; if (if4.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL rstmid_refill_ready%0d: got %b expected 1", i, if4.FD_w_ready); end
      tick();
    end
    if4.FD_w_valid = 1'b0;
    numChecks++; if (if4.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL rstmid_refill_full: got %b expected 0", if4.FD_w_ready); end
  endtask

  task automatic test_rows1();
    if1.FD_w_valid = 1'b1;
    if1.FD_w_data  = DW'(7);
    tick();
    if1.FD_w_valid = 1'b0;
    numChecks++; if (if1.FD_w_ready !== 1'b0) begin numFails++; $display("[TB] FAIL rows1_ready_full: got %b expected 0", if1.FD_w_ready); end
    if1.FD_load_start = 1'b1;
    tick();
    if1.FD_load_start = 1'b0;
    numChecks++; if (if1.FD_en_up !== 1'b1) begin numFails++; $display("[TB] FAIL rows1_en_c1: got %b expected 1", if1.FD_en_up); end
    numChecks++; if (if1.FD_data_up !== DW'(7)) begin numFails++; $display("[TB] FAIL rows1_data_c1: got %0d expected 7", if1.FD_data_up); end
    numChecks++; if (if1.FD_load_done !== 1'b0) begin numFails++; $display("[TB] FAIL rows1_done_c1: got %b expected 0", if1.FD_load_done); end
    tick();
    numChecks++; if (if1.FD_en_up !== 1'b0) begin numFails++; $display("[TB] FAIL rows1_en_c2: got %b expected 0", if1.FD_en_up); end
    numChecks++; if (if1.FD_data_up !== '0) begin numFails++; $display("[TB] FAIL rows1_data_c2: got %0d expected 0", if1.FD_data_up); end
    numChecks++; if (if1.FD_load_done !== 1'b1) begin numFails++; $display("[TB] FAIL rows1_done_c2: got %b expected 1", if1.FD_load_done); end
    numChecks++; if (if1.FD_col_loaded !== 1'b1) begin numFails++; $display("[TB] FAIL rows1_col_c2: got %b expected 1", if1.FD_col_loaded); end
    numChecks++; if (if1.FD_w_ready !== 1'b1) begin numFails++; $display("[TB] FAIL rows1_ready_c2: got %b expected 1", if1.FD_w_ready); end
    tick();
    numChecks++; if (if1.FD_load_done !== 1'b0) begin numFails++; $display("[TB] FAIL rows1_done_c3: got %b expected 0", if1.FD_load_done); end
    numChecks++; if (if1.FD_col_loaded !== 1'b1) begin numFails++; $display("[TB] FAIL rows1_col_c3: got %b expected 1", if1.FD_col_loaded); end
  endtask

`ifdef FD_BIAS_EN
  task automatic test_bias();
    logic [DW-1:0] biasVal;
    biasVal = 32'hFFFF_FFFB;
    if4.FD_bias_valid = 1'b1;
    if4.FD_bias_data  = biasVal;
    tick();
    if4.FD_bias_valid = 1'b0;
    numChecks++; if (if4.FD_data_up !== biasVal) begin numFails++; $display("[TB] FAIL bias_idle_data: got %0d expected -5", $signed(if4.FD_data_up)); end
    if4.FD_load_start = 1'b1;
    tick();
    if4.FD_load_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      numChecks++; if (if4.FD_en_up !== (c <= 4)) begin numFails++; $display("[TB] FAIL bias_en_up c%0d: got %b expected %b", c, if4.FD_en_up, (c <= 4)); end
      numChecks++; if (if4.FD_data_up !== ((c <= 4) ? DW'(25 - c) : biasVal)) begin numFails++; $display("[TB] FAIL bias_data_up c%0d: got %0d", c, $signed(if4.FD_data_up)); end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst               = 1'b1;
    if4.FD_w_valid    = 1'b0;
    if4.FD_w_data     = '0;
    if4.FD_load_start = 1'b0;
    if1.FD_w_valid    = 1'b0;
    if1.FD_w_data     = '0;
    if1.FD_load_start = 1'b0;
`ifdef FD_BIAS_EN
    if4.FD_bias_valid = 1'b0;
    if4.FD_bias_data  = '0;
    if1.FD_bias_valid = 1'b0;
    if1.FD_bias_data  = '0;
`endif
    test_reset();
    test_basic_load();
    test_early_start();
    test_back_to_back();
    test_reset_mid_shift();
    test_rows1();
`ifdef FD_BIAS_EN
    test_bias();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
